// File: rtl/psx_poll_scheduler.sv
// Frame-synchronous poll scheduler: one round per vsync edge polls ctrl 0 then ctrl 1
// through a shared transaction engine, with header check, retries and a watchdog.
module psx_poll_scheduler #(
   parameter int TIMEOUT_CYCLES = 100000,
   parameter int MAX_RETRY      = 2,
   parameter int GAP_CYCLES     = 200
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        vsync,
   input  logic        enable,
   output logic        txn_start,
   output logic        txn_abort,
   output logic [1:0]  txn_sel,
   input  logic        txn_done,
   input  logic        txn_err,
   input  logic        rx_valid,
   input  logic [3:0]  rx_addr,
   input  logic [7:0]  rx_byte,
   output logic [15:0] buttons0,
   output logic [15:0] buttons1,
   output logic [1:0]  present,
   output logic        frame_done,
   output logic        overrun
);

   localparam int WD_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam int GAP_W   = $clog2(GAP_CYCLES + 1);
   localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   // The abort decision is taken on the edge that moves the watchdog to TIMEOUT_CYCLES-1,
   // so the registered txn_abort is high in the cycle the count holds that value.
   localparam logic [WD_W-1:0]    WD_ABORT_AT = WD_W'(TIMEOUT_CYCLES - 2);
   localparam logic [GAP_W-1:0]   GAP_LAST    = GAP_W'(GAP_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRY);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_WAIT,
      S_CHECK,
      S_GAP,
      S_FINISH
   } state_t;

   state_t               state;
   logic                 vsync_q;
   logic                 vsync_rise;
   logic                 idx;
   logic [RETRY_W-1:0]   retry;
   logic                 again;
   logic                 hdr_ok;
   logic [15:0]          shadow;
   logic                 done_seen;
   logic                 err_seen;
   logic [WD_W-1:0]      wdog;
   logic [GAP_W-1:0]     gap_cnt;

   assign vsync_rise = vsync & ~vsync_q;

   function automatic logic [1:0] sel_of(input logic i);
      return i ? 2'b10 : 2'b01;
   endfunction

   // NOTE: all state below is sequential, so every assignment is non-blocking.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         vsync_q    <= 1'b0;
         idx        <= 1'b0;
         retry      <= '0;
         again      <= 1'b0;
         hdr_ok     <= 1'b0;
         shadow     <= 16'hFFFF;
         done_seen  <= 1'b0;
         err_seen   <= 1'b0;
         wdog       <= '0;
         gap_cnt    <= '0;
         txn_start  <= 1'b0;
         txn_abort  <= 1'b0;
         txn_sel    <= 2'b00;
         buttons0   <= 16'hFFFF;
         buttons1   <= 16'hFFFF;
         present    <= 2'b00;
         frame_done <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         vsync_q <= vsync;
         // NOTE: pulse outputs default low each cycle; only the branch that fires raises them.
         txn_start  <= 1'b0;
         txn_abort  <= 1'b0;
         frame_done <= 1'b0;

         if (vsync_rise && state != S_IDLE)
            overrun <= 1'b1;

         case (state)
            S_IDLE: begin
               if (vsync_rise && enable) begin
                  idx       <= 1'b0;
                  retry     <= '0;
                  txn_sel   <= sel_of(1'b0);
                  txn_start <= 1'b1;
                  state     <= S_START;
               end
            end

            S_START: begin
               hdr_ok    <= 1'b0;
               shadow    <= 16'hFFFF;
               done_seen <= 1'b0;
               err_seen  <= 1'b0;
               wdog      <= '0;
               state     <= S_WAIT;
            end

            S_WAIT: begin
               if (rx_valid) begin
                  case (rx_addr)
                     4'd2:    hdr_ok       <= (rx_byte == 8'h5A);
                     4'd3:    shadow[7:0]  <= rx_byte;
                     4'd4:    shadow[15:8] <= rx_byte;
                     default: ;
                  endcase
               end
               wdog <= wdog + 1'b1;
               // A completion in the deciding cycle beats the watchdog.
               if (txn_done) begin
                  done_seen <= 1'b1;
                  err_seen  <= txn_err;
                  state     <= S_CHECK;
               end else if (wdog == WD_ABORT_AT) begin
                  txn_abort <= 1'b1;
                  state     <= S_CHECK;
               end
            end

            S_CHECK: begin
               txn_sel <= 2'b00;
               gap_cnt <= '0;
               state   <= S_GAP;
               if (done_seen && !err_seen && hdr_ok) begin
                  if (idx) buttons1 <= shadow;
                  else     buttons0 <= shadow;
                  present[idx] <= 1'b1;
                  again        <= 1'b0;
               end else if (retry < RETRY_MAX) begin
                  retry <= retry + 1'b1;
                  again <= 1'b1;
               end else begin
                  // Give up: report all buttons released so nothing stays stuck.
                  if (idx) buttons1 <= 16'hFFFF;
                  else     buttons0 <= 16'hFFFF;
                  present[idx] <= 1'b0;
                  again        <= 1'b0;
               end
            end

            S_GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  if (again) begin
                     txn_sel   <= sel_of(idx);
                     txn_start <= 1'b1;
                     state     <= S_START;
                  end else if (!idx) begin
                     idx       <= 1'b1;
                     retry     <= '0;
                     txn_sel   <= sel_of(1'b1);
                     txn_start <= 1'b1;
                     state     <= S_START;
                  end else begin
                     frame_done <= 1'b1;
                     state      <= S_FINISH;
                  end
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end

            S_FINISH: state <= S_IDLE;

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_psx_poll_scheduler.sv
// Bench for psx_poll_scheduler: scripted engine, per-cycle expectation tables built
// from the polling rules, and literal checks on each round's outcome.
module tb_psx_poll_scheduler;

   localparam int T     = 50;
   localparam int MAXR  = 2;
   localparam int G     = 8;
   localparam int WAITN = 6;     // WAIT cycles of a completed engine transaction
   localparam int N     = 4096;

   typedef enum int {K_GOOD, K_BADHDR, K_ERR, K_TIMEOUT} kind_t;

   logic        clk;
   logic        rst;
   logic        vsync;
   logic        enable;
   logic        txn_start;
   logic        txn_abort;
   logic [1:0]  txn_sel;
   logic        txn_done;
   logic        txn_err;
   logic        rx_valid;
   logic [3:0]  rx_addr;
   logic [7:0]  rx_byte;
   logic [15:0] buttons0;
   logic [15:0] buttons1;
   logic [1:0]  present;
   logic        frame_done;
   logic        overrun;

   psx_poll_scheduler #(
      .TIMEOUT_CYCLES(T),
      .MAX_RETRY(MAXR),
      .GAP_CYCLES(G)
   ) dut (
      .clk(clk),
      .rst(rst),
      .vsync(vsync),
      .enable(enable),
      .txn_start(txn_start),
      .txn_abort(txn_abort),
      .txn_sel(txn_sel),
      .txn_done(txn_done),
      .txn_err(txn_err),
      .rx_valid(rx_valid),
      .rx_addr(rx_addr),
      .rx_byte(rx_byte),
      .buttons0(buttons0),
      .buttons1(buttons1),
      .present(present),
      .frame_done(frame_done),
      .overrun(overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scenario: per controller, what the engine does on each attempt of a round.
   kind_t       sc_kind [2][3];
   logic [15:0] sc_val  [2][3];
   int          eng_cnt [2];

   task automatic set_ctrl(input int n, input kind_t k0, input kind_t k1, input kind_t k2,
                           input logic [15:0] v0, input logic [15:0] v1, input logic [15:0] v2);
      sc_kind[n][0] = k0; sc_kind[n][1] = k1; sc_kind[n][2] = k2;
      sc_val[n][0]  = v0; sc_val[n][1]  = v1; sc_val[n][2]  = v2;
      eng_cnt[n]    = 0;
   endtask

   function automatic logic [7:0] eng_byte(input int i, input kind_t k, input logic [15:0] v);
      case (i)
         0:       return 8'hFF;
         1:       return 8'h41;
         2:       return (k == K_BADHDR) ? 8'h00 : 8'h5A;
         3:       return v[7:0];
         default: return v[15:8];
      endcase
   endfunction

   // Engine: bytes 0..4 on consecutive cycles after txn_start, then txn_done.
   initial begin
      int          n;
      int          a;
      kind_t       k;
      logic [15:0] v;
      rx_valid = 1'b0; rx_addr = '0; rx_byte = '0; txn_done = 1'b0; txn_err = 1'b0;
      forever begin
         @(negedge clk);
         if (txn_start) begin
            n = txn_sel[1] ? 1 : 0;
            a = eng_cnt[n];
            eng_cnt[n]++;
            k = (a < 3) ? sc_kind[n][a] : K_TIMEOUT;
            v = (a < 3) ? sc_val[n][a] : 16'hFFFF;
            if (k != K_TIMEOUT) begin
               for (int i = 0; i < 5; i++) begin
                  @(negedge clk);
                  rx_valid = 1'b1; rx_addr = 4'(i); rx_byte = eng_byte(i, k, v);
               end
               @(negedge clk);
               rx_valid = 1'b0; txn_done = 1'b1; txn_err = (k == K_ERR);
               @(negedge clk);
               txn_done = 1'b0; txn_err = 1'b0;
            end
         end
      end
   end

   // Expected output of every cycle.
   bit          exp_start [N];
   bit          exp_abort [N];
   bit          exp_fd    [N];
   bit          exp_ovr   [N];
   logic [1:0]  exp_sel   [N];
   logic [1:0]  exp_pres  [N];
   logic [15:0] exp_b0    [N];
   logic [15:0] exp_b1    [N];

   task automatic model_reset(input int from);
      for (int c = from; c < N; c++) begin
         exp_start[c] = 0; exp_abort[c] = 0; exp_fd[c] = 0; exp_ovr[c] = 0;
         exp_sel[c] = 2'b00; exp_pres[c] = 2'b00; exp_b0[c] = 16'hFFFF; exp_b1[c] = 16'hFFFF;
      end
   endtask

   task automatic fill_result(input int from, input int n, input logic [15:0] v, input bit p);
      for (int c = from; c < N; c++) begin
         if (n == 0) exp_b0[c] = v;
         else        exp_b1[c] = v;
         exp_pres[c][n] = p;
      end
   endtask

   // Round seen at edge cycle e: each attempt is START, its WAIT span, CHECK, then G gap
   // cycles; a controller succeeds on its first good attempt or gives up after MAXR retries.
   task automatic model_round(input int e, output int fd_cycle);
      int t;
      int w;
      int tc;
      t = e + 1;
      for (int n = 0; n < 2; n++) begin
         for (int a = 0; a <= MAXR; a++) begin
            w = (sc_kind[n][a] == K_TIMEOUT) ? T - 1 : WAITN;
            exp_start[t] = 1;
            for (int c = t; c <= t + w + 1; c++) exp_sel[c] = (n == 0) ? 2'b01 : 2'b10;
            if (sc_kind[n][a] == K_TIMEOUT) exp_abort[t + w + 1] = 1;
            tc = t + w + 2;
            t  = tc + G;
            if (sc_kind[n][a] == K_GOOD) begin
               fill_result(tc, n, sc_val[n][a], 1'b1);
               break;
            end else if (a == MAXR) begin
               fill_result(tc, n, 16'hFFFF, 1'b0);
            end
         end
      end
      exp_fd[t] = 1;
      fd_cycle  = t;
   endtask

   // Event monitor for the literal checks.
   int start_cnt [2];
   int abort_cnt;
   int fd_cnt;
   int first_start;
   int first_abort;

   task automatic clear_mon();
      start_cnt[0] = 0; start_cnt[1] = 0; abort_cnt = 0; fd_cnt = 0;
      first_start = -1; first_abort = -1;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (cyc >= N) begin
            n_tests++;
            n_fail++;
            $display("FAIL cycle_budget: got %0d, expected below %0d", cyc, N);
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $fatal(1);
         end
         check("txn_start",  txn_start,  exp_start[cyc]);
         check("txn_abort",  txn_abort,  exp_abort[cyc]);
         check("txn_sel",    txn_sel,    exp_sel[cyc]);
         check("frame_done", frame_done, exp_fd[cyc]);
         check("buttons0",   buttons0,   exp_b0[cyc]);
         check("buttons1",   buttons1,   exp_b1[cyc]);
         check("present",    present,    exp_pres[cyc]);
         check("overrun",    overrun,    exp_ovr[cyc]);
         if (txn_start) begin
            start_cnt[txn_sel[1]]++;
            if (first_start < 0) first_start = cyc;
         end
         if (txn_abort) begin
            abort_cnt++;
            if (first_abort < 0) first_abort = cyc;
         end
         if (frame_done) fd_cnt++;
      end
   end

   task automatic wait_until(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic fire_round(output int e, output int fd_cycle);
      @(negedge clk);
      e = cyc;
      model_round(e, fd_cycle);
      vsync = 1'b1;
      @(negedge clk);
      vsync = 1'b0;
   endtask

   initial begin
      int e;
      int fdc;
      model_reset(0);
      clear_mon();
      rst = 1'b0; vsync = 1'b0; enable = 1'b1;
      set_ctrl(0, K_GOOD, K_GOOD, K_GOOD, 16'hFFFF, 16'hFFFF, 16'hFFFF);
      set_ctrl(1, K_GOOD, K_GOOD, K_GOOD, 16'hFFFF, 16'hFFFF, 16'hFFFF);
      #2 rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_buttons0", buttons0, 16'hFFFF);
      check("reset_present",  present,  2'b00);

      // Clean round
      set_ctrl(0, K_GOOD, K_GOOD, K_GOOD, 16'hFFF7, 16'hFFF7, 16'hFFF7);
      set_ctrl(1, K_GOOD, K_GOOD, K_GOOD, 16'hFEFF, 16'hFEFF, 16'hFEFF);
      clear_mon();
      fire_round(e, fdc);
      wait_until(fdc + 3);
      check("clean_start_latency", first_start, e + 1);
      check("clean_buttons0", buttons0, 16'hFFF7);
      check("clean_buttons1", buttons1, 16'hFEFF);
      check("clean_present",  present,  2'b11);
      check("clean_frame_done_count", fd_cnt, 1);
      check("clean_start_count", start_cnt[0] + start_cnt[1], 2);

      // Bad header on every ctrl 0 attempt
      set_ctrl(0, K_BADHDR, K_BADHDR, K_BADHDR, 16'h0000, 16'h0000, 16'h0000);
      set_ctrl(1, K_GOOD, K_GOOD, K_GOOD, 16'h1234, 16'h1234, 16'h1234);
      clear_mon();
      fire_round(e, fdc);
      wait_until(fdc + 3);
      check("badhdr_attempts0", start_cnt[0], 3);
      check("badhdr_attempts1", start_cnt[1], 1);
      check("badhdr_buttons0",  buttons0, 16'hFFFF);
      check("badhdr_buttons1",  buttons1, 16'h1234);
      check("badhdr_present",   present,  2'b10);

      // Engine never completes ctrl 0
      set_ctrl(0, K_TIMEOUT, K_TIMEOUT, K_TIMEOUT, 16'h0000, 16'h0000, 16'h0000);
      set_ctrl(1, K_GOOD, K_GOOD, K_GOOD, 16'hABCD, 16'hABCD, 16'hABCD);
      clear_mon();
      fire_round(e, fdc);
      wait_until(fdc + 3);
      check("timeout_abort_wait_index", first_abort - (first_start + 1), 49);
      check("timeout_abort_count", abort_cnt, 3);
      check("timeout_present",  present,  2'b10);
      check("timeout_buttons0", buttons0, 16'hFFFF);

      // Engine error once, then a good reply
      set_ctrl(0, K_ERR, K_GOOD, K_GOOD, 16'h1111, 16'hFFF0, 16'hFFF0);
      set_ctrl(1, K_GOOD, K_GOOD, K_GOOD, 16'hFEFF, 16'hFEFF, 16'hFEFF);
      clear_mon();
      fire_round(e, fdc);
      wait_until(fdc + 3);
      check("recover_attempts0", start_cnt[0], 2);
      check("recover_buttons0",  buttons0, 16'hFFF0);
      check("recover_present",   present,  2'b11);

      // Second edge and enable drop mid-round
      set_ctrl(0, K_GOOD, K_GOOD, K_GOOD, 16'h1357, 16'h1357, 16'h1357);
      set_ctrl(1, K_GOOD, K_GOOD, K_GOOD, 16'h2468, 16'h2468, 16'h2468);
      clear_mon();
      fire_round(e, fdc);
      wait_until(e + 10);
      for (int c = e + 11; c < N; c++) exp_ovr[c] = 1;
      vsync = 1'b1;
      @(negedge clk);
      vsync = 1'b0;
      @(negedge clk);
      enable = 1'b0;
      wait_until(fdc + 3);
      check("overrun_flag",     overrun,  1'b1);
      check("overrun_buttons0", buttons0, 16'h1357);
      check("overrun_buttons1", buttons1, 16'h2468);
      check("overrun_frame_done_count", fd_cnt, 1);

      // Edge while disabled starts nothing
      clear_mon();
      @(negedge clk);
      vsync = 1'b1;
      @(negedge clk);
      vsync = 1'b0;
      repeat (20) @(negedge clk);
      check("disabled_starts", start_cnt[0] + start_cnt[1], 0);
      check("disabled_frame_done", fd_cnt, 0);
      enable = 1'b1;

      // Reset in the middle of a WAIT
      set_ctrl(0, K_GOOD, K_GOOD, K_GOOD, 16'hAAAA, 16'hAAAA, 16'hAAAA);
      set_ctrl(1, K_GOOD, K_GOOD, K_GOOD, 16'h5555, 16'h5555, 16'h5555);
      clear_mon();
      fire_round(e, fdc);
      wait_until(e + 3);
      model_reset(e + 4);
      rst = 1'b1;
      #1;
      check("reset_mid_sel",      txn_sel,  2'b00);
      check("reset_mid_buttons0", buttons0, 16'hFFFF);
      check("reset_mid_buttons1", buttons1, 16'hFFFF);
      check("reset_mid_present",  present,  2'b00);
      check("reset_mid_overrun",  overrun,  1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (15) @(negedge clk);

      // Fresh round after reset
      set_ctrl(0, K_GOOD, K_GOOD, K_GOOD, 16'h7E81, 16'h7E81, 16'h7E81);
      set_ctrl(1, K_GOOD, K_GOOD, K_GOOD, 16'hFEFF, 16'hFEFF, 16'hFEFF);
      clear_mon();
      fire_round(e, fdc);
      wait_until(fdc + 3);
      check("fresh_start_latency", first_start, e + 1);
      check("fresh_buttons0", buttons0, 16'h7E81);
      check("fresh_present",  present,  2'b11);
      check("fresh_frame_done_count", fd_cnt, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
